piano_mode_sched: RTL
=====================

// Module: piano_mode_sched
// PURPOSE
//  Sequences sharing of the single tone path (note -> FREQ mux, segment display, Led bank) between
//  three note sources: lesson-mode switches, autoplay song 1, autoplay song 2. Replaces the
//  free-running mode register: arbitrates mode buttons, issues start/stop to the song players,
//  inserts a silent gap between sources, and enforces a per-song beat timeout.
// PARAMETERS
//  GAP_BEATS  2      quarter beats of forced rest on every source change (1..15)
//  MAX_BEATS  256    timeout in quarter beats for one song run (1..65535)
//  REST_CODE  4'd0   note code meaning silence
//  LOOP       0      1 = song restarts after done (via GAP); 0 = return to lesson mode
// PORTS
//  CLK          in   1   system clock
//  RESET        in   1   asynchronous, active-high reset
//  beat_tick    in   1   one-CLK-cycle pulse per quarter beat, synchronous to CLK
//  req_lesson   in   1   debounced one-cycle pulse: request lesson mode
//  req_song1    in   1   debounced one-cycle pulse: request autoplay song 1
//  req_song2    in   1   debounced one-cycle pulse: request autoplay song 2
//  sw_note      in   4   note decoded from lesson switches
//  song1_note   in   4   current note of song 1 player
//  song1_done   in   1   level/pulse: song 1 finished last note
//  song2_note   in   4   current note of song 2 player
//  song2_done   in   1   level/pulse: song 2 finished last note
//  song1_start  out  1   one-cycle pulse: restart song 1 from first note
//  song2_start  out  1   one-cycle pulse: restart song 2 from first note
//  song_stop    out  1   one-cycle pulse: abort whichever song is running
//  note         out  4   arbitrated note to FREQ mux and display (registered)
//  src          out  2   owner: 00 lesson, 01 song1, 10 song2, 11 gap
//  timeout      out  1   sticky flag: a song hit MAX_BEATS; cleared by next accepted request
// BEHAVIOUR
//  Reset: state LESSON; note=REST_CODE, src=00, all pulses 0, timeout=0, pending=none, counters 0.
//  States: LESSON, GAP, SONG1, SONG2. note/src registered, update 1 cycle after state change.
//  Request arbitration (same cycle): req_lesson > req_song1 > req_song2; losers dropped.
//  LESSON: note=sw_note. Request for song N -> pending=N, GAP. req_lesson ignored.
//  GAP: note=REST_CODE, src=11. Gap counter counts beat_tick; after GAP_BEATS ticks:
//   pending song N -> SONGN with songN_start pulsed on the transition cycle; pending lesson -> LESSON.
//   New request during GAP overwrites pending and restarts gap counter at 0.
//  SONGN: note=songN_note; beat counter counts beat_tick from 0.
//   songN_done -> LOOP ? (pending=N, GAP) : (pending=lesson, GAP).
//   beat counter reaches MAX_BEATS -> song_stop pulse, timeout=1, pending=lesson, GAP.
//   Any request (incl. same song) -> song_stop pulse, pending=request, GAP.
//   Request and done same cycle: request wins. done from the non-active song is ignored.
//  Start pulses fire exactly once per entry into SONGN; song_stop never coincides with a start.
//  Counters saturate-free: gap counter 4 b, beat counter 16 b, both cleared on every state entry.
//  beat_tick coincident with state entry counts toward the new state's counter? No: ignored.
//  RESET asserted mid-song: immediate return to reset values, no song_stop pulse issued.
// TESTING
//  1) Reset, sw_note=4'd3 -> note=3, src=00, no pulses.
//  2) req_song1 in LESSON, GAP_BEATS=2 -> src=11 note=0 for 2 ticks, then song1_start 1 cycle, src=01, note=song1_note.
//  3) SONG1, req_song2 -> song_stop 1 cycle, GAP, then song2_start, src=10; song1_done afterwards ignored.
//  4) req_lesson+req_song2 same cycle from LESSON -> both ignored (lesson wins, no-op); from SONG2 -> stop, GAP, LESSON.
//  5) MAX_BEATS=4, song never done -> after 4 ticks song_stop, timeout=1, GAP, LESSON; next request clears timeout.
//  6) LOOP=1, song2_done -> GAP then second song2_start; RESET mid-song -> src=00, note=0 next cycle.

Source files
------------

// File: rtl/piano_mode_sched.sv
// piano_mode_sched: owns the shared tone path (note mux, display, LEDs) and hands it
// between lesson-mode switches and two autoplay song players. Every change of source
// goes through a silent gap of GAP_BEATS quarter beats. A song run is capped at
// MAX_BEATS quarter beats.
module piano_mode_sched #(
    parameter int unsigned GAP_BEATS = 2,
    parameter int unsigned MAX_BEATS = 256,
    parameter logic [3:0]  REST_CODE = 4'd0,
    parameter bit          LOOP      = 1'b0
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       beat_tick,
    input  logic       req_lesson,
    input  logic       req_song1,
    input  logic       req_song2,
    input  logic [3:0] sw_note,
    input  logic [3:0] song1_note,
    input  logic       song1_done,
    input  logic [3:0] song2_note,
    input  logic       song2_done,
    output logic       song1_start,
    output logic       song2_start,
    output logic       song_stop,
    output logic [3:0] note,
    output logic [1:0] src,
    output logic       timeout
);

    typedef enum logic [1:0] {StLesson, StGap, StSong1, StSong2} state_e;
    typedef enum logic [1:0] {PendNone, PendLesson, PendSong1, PendSong2} pend_e;

    // Terminal counts: the transition fires on the tick that would complete the count.
    localparam logic [3:0]  GapLast  = 4'(GAP_BEATS - 1);
    localparam logic [15:0] BeatLast = 16'(MAX_BEATS - 1);

    state_e      state_q, state_d;
    pend_e       pend_q, pend_d;
    logic        timeout_q, timeout_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic [15:0] beat_cnt_q, beat_cnt_d;
    logic [3:0]  note_q;
    logic [1:0]  src_q;

    pend_e req_win;
    pend_e own_pend;
    logic  req_any;
    logic  in_song;
    logic  own_done;
    logic  lesson_go;
    logic  gap_restart;
    logic  gap_end;
    logic  song_abort;
    logic  song_fin;
    logic  song_tmo;

    // Fixed-priority request arbitration; losing requests are simply dropped.
    always_comb begin
        req_win = PendNone;
        if (req_lesson) begin
            req_win = PendLesson;
        end else if (req_song1) begin
            req_win = PendSong1;
        end else if (req_song2) begin
            req_win = PendSong2;
        end
        req_any = (req_win != PendNone);
    end

    // Decode the events that move the FSM; shared by next-state and pulse outputs.
    always_comb begin
        in_song  = (state_q == StSong1) || (state_q == StSong2);
        own_pend = (state_q == StSong2) ? PendSong2 : PendSong1;
        own_done = 1'b0;
        if (state_q == StSong1) begin
            own_done = song1_done;
        end else if (state_q == StSong2) begin
            own_done = song2_done;
        end
        // Lesson request while already in lesson mode is a no-op.
        lesson_go   = (state_q == StLesson) &&
                      ((req_win == PendSong1) || (req_win == PendSong2));
        gap_restart = (state_q == StGap) && req_any;
        gap_end     = (state_q == StGap) && !req_any && beat_tick && (gap_cnt_q == GapLast);
        // Request beats done, done beats timeout.
        song_abort  = in_song && req_any;
        song_fin    = in_song && !req_any && own_done;
        song_tmo    = in_song && !req_any && !own_done && beat_tick &&
                      (beat_cnt_q == BeatLast);
    end

    // State, pending owner and sticky timeout registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= StLesson;
            pend_q    <= PendNone;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        timeout_d = timeout_q;
        if (lesson_go || gap_restart || song_abort) begin
            // Any accepted request clears the timeout flag.
            state_d   = StGap;
            pend_d    = req_win;
            timeout_d = 1'b0;
        end else if (song_fin) begin
            state_d = StGap;
            pend_d  = LOOP ? own_pend : PendLesson;
        end else if (song_tmo) begin
            state_d   = StGap;
            pend_d    = PendLesson;
            timeout_d = 1'b1;
        end else if (gap_end) begin
            pend_d = PendNone;
            case (pend_q)
                PendSong1: state_d = StSong1;
                PendSong2: state_d = StSong2;
                default:   state_d = StLesson;
            endcase
        end
    end

    // Gap and beat counters; cleared on every state entry so an entry-cycle tick is lost.
    always_comb begin
        gap_cnt_d  = gap_cnt_q;
        beat_cnt_d = beat_cnt_q;
        if ((state_d != state_q) || gap_restart) begin
            gap_cnt_d  = 4'd0;
            beat_cnt_d = 16'd0;
        end else if (beat_tick) begin
            if (state_q == StGap) begin
                gap_cnt_d = gap_cnt_q + 4'd1;
            end
            if (in_song) begin
                beat_cnt_d = beat_cnt_q + 16'd1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            gap_cnt_q  <= 4'd0;
            beat_cnt_q <= 16'd0;
        end else begin
            gap_cnt_q  <= gap_cnt_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Registered note/owner mux, following the current state one cycle later.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            note_q <= REST_CODE;
            src_q  <= 2'b00;
        end else begin
            unique case (state_q)
                StLesson: begin
                    note_q <= sw_note;
                    src_q  <= 2'b00;
                end
                StSong1: begin
                    note_q <= song1_note;
                    src_q  <= 2'b01;
                end
                StSong2: begin
                    note_q <= song2_note;
                    src_q  <= 2'b10;
                end
                StGap: begin
                    note_q <= REST_CODE;
                    src_q  <= 2'b11;
                end
            endcase
        end
    end

    // Player control pulses: starts only leave GAP, stop only leaves a song, so never together.
    always_comb begin
        song1_start = gap_end && (pend_q == PendSong1);
        song2_start = gap_end && (pend_q == PendSong2);
        song_stop   = song_abort || song_tmo;
        note        = note_q;
        src         = src_q;
        timeout     = timeout_q;
    end

endmodule
